booth_mult_arbiter: RTL and testbench

Round-robin arbiter and scheduler that shares one pipelined radix-4 Booth multiplier (a chain of WIDTH/2 Booth step stages plus a final adder) among NREQ requesters, such as the DCT and quantiser lanes. It accepts at most one operand pair per cycle and tags each issue with its requester index. It tracks the tag through a delay line matched to the multiplier latency and routes each product back to its originator. It also checks that multiplier result-valid lines up with the tag pipeline.

---
 rtl/booth_arb_pkg.sv | 23 ++
 rtl/booth_tag_pipe.sv | 32 +++
 rtl/booth_mult_arbiter.sv | 102 ++++++++++
 tb/tb_booth_mult_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/booth_arb_pkg.sv
// Shared constants, tag type and one-hot helper for the Booth multiplier arbiter.
package booth_arb_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 4;
    localparam int DEF_LAT   = 5;
    localparam int MAX_NREQ  = 8;
    localparam int TAG_IDX_W = $clog2(MAX_NREQ);

    // Index field is sized for the largest supported requester count.
    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

    function automatic logic [MAX_NREQ-1:0] onehot_idx(input logic [TAG_IDX_W-1:0] idx);
        logic [MAX_NREQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/booth_tag_pipe.sv
// Requester-tag delay line matched to the multiplier latency.
module booth_tag_pipe
    import booth_arb_pkg::*;
#(
    parameter int LAT = DEF_LAT
) (
    input  logic clk,
    input  logic nrst,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic any_valid
);

    tag_t stg_p [LAT];

    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < LAT; i++) stg_p[i] <= '0;
        end else begin
            stg_p[0] <= tag_in;
            for (int i = 1; i < LAT; i++) stg_p[i] <= stg_p[i-1];
        end
    end

    assign tag_out = stg_p[LAT-1];

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < LAT; i++) any_valid = any_valid | stg_p[i].valid;
    end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin scheduler sharing one pipelined Booth multiplier among NREQ requesters,
// tagging each issue and routing products back to their originators.
module booth_mult_arbiter
    import booth_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int LAT   = DEF_LAT
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      hold,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    output logic [NREQ-1:0]           gnt,
    output logic signed [WIDTH-1:0]   mul_a,
    output logic signed [WIDTH-1:0]   mul_b,
    output logic                      mul_valid,
    input  logic signed [2*WIDTH-1:0] res,
    input  logic                      res_valid,
    output logic signed [2*WIDTH-1:0] rsp_data,
    output logic [NREQ-1:0]           rsp_valid,
    output logic                      busy,
    output logic                      err
);

    logic [TAG_IDX_W-1:0] ptr;
    logic [TAG_IDX_W-1:0] gnt_idx_p0;
    logic                 gnt_any_p0;
    logic [TAG_IDX_W-1:0] tag_idx_p1;
    tag_t                 tag_in;
    tag_t                 tag_out;
    logic                 tags_live;

    // Stage p0: round-robin scan from ptr; reset and hold both suppress the grant.
    always_comb begin
        int j;
        j          = 0;
        gnt_any_p0 = 1'b0;
        gnt_idx_p0 = '0;
        if (nrst && !hold) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (int'(ptr) + k) % NREQ;
                if (!gnt_any_p0 && req[j]) begin
                    gnt_any_p0 = 1'b1;
                    gnt_idx_p0 = TAG_IDX_W'(j);
                end
            end
        end
        gnt = gnt_any_p0 ? NREQ'(onehot_idx(gnt_idx_p0)) : '0;
    end

    // Stage p1: issue registers feeding the multiplier and the tag line.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            ptr        <= '0;
            mul_valid  <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            tag_idx_p1 <= '0;
        end else begin
            mul_valid <= gnt_any_p0;
            if (gnt_any_p0) begin
                mul_a      <= req_a[int'(gnt_idx_p0)*WIDTH +: WIDTH];
                mul_b      <= req_b[int'(gnt_idx_p0)*WIDTH +: WIDTH];
                tag_idx_p1 <= gnt_idx_p0;
                ptr        <= (int'(gnt_idx_p0) == NREQ-1) ? '0 : gnt_idx_p0 + 1'b1;
            end
        end
    end

    assign tag_in = '{valid: mul_valid, idx: tag_idx_p1};

    booth_tag_pipe #(.LAT(LAT)) u_tag_pipe (
        .clk       (clk),
        .nrst      (nrst),
        .tag_in    (tag_in),
        .tag_out   (tag_out),
        .any_valid (tags_live)
    );

    // Stage p2: route product to its tag; a beat without a matching tag is dropped and flagged.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            err       <= 1'b0;
        end else begin
            if (res_valid && tag_out.valid) begin
                rsp_data  <= res;
                rsp_valid <= NREQ'(onehot_idx(tag_out.idx));
            end else begin
                rsp_valid <= '0;
            end
            if (res_valid ^ tag_out.valid) err <= 1'b1;
        end
    end

    assign busy = mul_valid | tags_live;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench: arbiter driving a behavioural LAT-cycle multiplier model.
module tb_booth_mult_arbiter;

    localparam int W = 8;
    localparam int N = 4;
    localparam int L = 5;

    logic           clk = 1'b0;
    logic           nrst;
    logic           hold;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   gnt;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic           mul_valid;
    logic [2*W-1:0] res;
    logic           res_valid;
    logic [2*W-1:0] rsp_data;
    logic [N-1:0]   rsp_valid;
    logic           busy;
    logic           err;
    logic           inj;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    booth_mult_arbiter #(.WIDTH(W), .NREQ(N), .LAT(L)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .hold      (hold),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt       (gnt),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_valid (mul_valid),
        .res       (res),
        .res_valid (res_valid),
        .rsp_data  (rsp_data),
        .rsp_valid (rsp_valid),
        .busy      (busy),
        .err       (err)
    );

    // Multiplier model: signed product delayed L cycles, reset with the arbiter.
    logic [L-1:0]   pv;
    logic [2*W-1:0] pp [L];

    always_ff @(posedge clk) begin
        if (!nrst) pv <= '0;
        else       pv <= {pv[L-2:0], mul_valid};
        pp[0] <= $signed({{W{mul_a[W-1]}}, mul_a}) * $signed({{W{mul_b[W-1]}}, mul_b});
        for (int i = 1; i < L; i++) pp[i] <= pp[i-1];
    end

    assign res       = pp[L-1];
    assign res_valid = pv[L-1] | inj;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // Issue one lone request and check grant, latency and routed product.
    task automatic single(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] prod, input string tag);
        int t0;
        set_ops(i, a, b);
        req = N'(1 << i);
        #1;
        chk({tag, "_gnt"}, 32'(gnt), 32'(1 << i));
        t0 = cyc;
        tick();
        req = '0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        for (int k = 0; k < 12; k++) begin
            if (rsp_valid != '0) break;
            tick();
        end
        chk({tag, "_lat"}, 32'(cyc - t0), 32'd7);
        chk({tag, "_rspv"}, 32'(rsp_valid), 32'(1 << i));
        chk({tag, "_data"}, 32'(rsp_data), 32'(prod));
        chk({tag, "_busy0"}, 32'(busy), 32'd0);
    endtask

    logic [2*W-1:0] exp_prod [N];
    int n_rsp;

    initial begin
        nrst = 1'b0; hold = 1'b0; req = '1; req_a = '0; req_b = '0; inj = 1'b0;
        exp_prod = '{16'h000A, 16'h0028, 16'h005A, 16'h00A0};

        tick(); tick();
        chk("rst_gnt",  32'(gnt), 32'd0);
        chk("rst_mulv", 32'(mul_valid), 32'd0);
        chk("rst_mula", 32'(mul_a), 32'd0);
        chk("rst_rspv", 32'(rsp_valid), 32'd0);
        chk("rst_data", 32'(rsp_data), 32'd0);
        chk("rst_err",  32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        nrst = 1'b1; req = '0;
        tick();

        // ptr 0 -> 3 after this grant
        single(2, 8'hFD, 8'h07, 16'hFFEB, "neg");
        // ptr 3, only req[0]: wrap-around, ptr -> 1
        single(0, 8'h80, 8'h80, 16'h4000, "wrap_min");
        single(1, 8'h7F, 8'h80, 16'hC080, "maxmin");

        // Continuous all-request from ptr 0
        nrst = 1'b0; tick(); nrst = 1'b1;
        for (int i = 0; i < N; i++) set_ops(i, W'(i + 1), W'(10 * (i + 1)));
        n_rsp = 0;
        for (int c = 0; c < 20; c++) begin
            req = (c < 8) ? '1 : '0;
            #1;
            if (c < 8) chk("rr_gnt", 32'(gnt), 32'(1 << (c % N)));
            if (rsp_valid != '0) begin
                chk("rr_rspv", 32'(rsp_valid), 32'(1 << (n_rsp % N)));
                chk("rr_data", 32'(rsp_data), 32'(exp_prod[n_rsp % N]));
                n_rsp++;
            end
            tick();
        end
        chk("rr_count", 32'(n_rsp), 32'd8);

        // hold for three cycles mid-stream; ptr resumes where it stopped
        n_rsp = 0;
        for (int c = 0; c < 20; c++) begin
            req  = (c < 6) ? '1 : '0;
            hold = (c >= 2 && c <= 4);
            #1;
            if (c < 2)               chk("hold_pre_gnt", 32'(gnt), 32'(1 << c));
            if (c >= 2 && c <= 4)    chk("hold_gnt", 32'(gnt), 32'd0);
            if (c == 3 || c == 4)    chk("hold_mulv", 32'(mul_valid), 32'd0);
            if (c == 5)              chk("hold_resume", 32'(gnt), 32'b0100);
            if (rsp_valid != '0) begin
                chk("hold_rspv", 32'(rsp_valid), 32'(1 << n_rsp));
                chk("hold_data", 32'(rsp_data), 32'(exp_prod[n_rsp % N]));
                n_rsp++;
            end
            tick();
        end
        hold = 1'b0;
        chk("hold_count", 32'(n_rsp), 32'd3);
        chk("hold_busy", 32'(busy), 32'd0);

        // Stray product with nothing in flight
        chk("err_pre", 32'(err), 32'd0);
        inj = 1'b1;
        tick();
        inj = 1'b0;
        chk("err_set", 32'(err), 32'd1);
        chk("err_rspv", 32'(rsp_valid), 32'd0);
        tick();
        chk("err_sticky", 32'(err), 32'd1);

        // Reset while requests are streaming
        req = '1;
        tick(); tick(); tick();
        nrst = 1'b0;
        tick();
        chk("mrst_gnt",  32'(gnt), 32'd0);
        chk("mrst_mulv", 32'(mul_valid), 32'd0);
        chk("mrst_mula", 32'(mul_a), 32'd0);
        chk("mrst_err",  32'(err), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_rspv", 32'(rsp_valid), 32'd0);
        nrst = 1'b1; req = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
